index_encoder_output: RTL and testbench



---
 rtl/index_encoder_output.sv | 123 ++++++++++++
 tb/tb_index_encoder_output.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/index_encoder_output.sv
// Dense-to-sparse activation encoder.
// Each nonzero value is paired with the count of zeros that preceded it, and
// entries are packed I per output vector. A zero run that reaches MAX_RUN is
// broken with a {0, MAX_RUN} filler entry so the run index never wraps.
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// producer holds data stable while valid && !ready. in_ready depends only on
// internal state, and out_valid never waits on out_ready.
module index_encoder_output #(
    parameter int I      = 4,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [I*DATA_W-1:0]   out_value,
    output logic [I*IDX_W-1:0]    out_index,
    output logic [$clog2(I):0]    out_cnt,
    output logic                  out_last
);

    localparam int CNT_W  = $clog2(I) + 1;
    localparam int SLOT_W = $clog2(I);
    localparam logic [IDX_W-1:0] MAX_RUN = '1;

    logic [DATA_W-1:0]   pack_value [I];
    logic [IDX_W-1:0]    pack_index [I];
    logic [I*DATA_W-1:0] pack_value_flat;
    logic [I*IDX_W-1:0]  pack_index_flat;
    logic [CNT_W-1:0]    pack_cnt;
    logic [IDX_W-1:0]    run;
    logic                flush_pend;

    logic accept;
    logic is_zero;
    logic write_slot;
    logic pack_full;
    logic out_free;
    logic transfer;

    // The pack stops accepting once full or once a frame close is waiting, so
    // accepting an element and moving the pack to the output never coincide.
    assign pack_full  = (pack_cnt == CNT_W'(I));
    assign in_ready   = !pack_full && !flush_pend;
    assign accept     = in_valid && in_ready;
    assign is_zero    = (in_data == '0);
    assign write_slot = accept && (!is_zero || (run == MAX_RUN));
    assign out_free   = !out_valid || out_ready;
    assign transfer   = (pack_full || flush_pend) && out_free;

    // Flatten the pack slots, slot 0 in the least significant position.
    always_comb begin
        pack_value_flat = '0;
        pack_index_flat = '0;
        for (int k = 0; k < I; k++) begin
            pack_value_flat[k*DATA_W +: DATA_W] = pack_value[k];
            pack_index_flat[k*IDX_W +: IDX_W]   = pack_index[k];
        end
    end

    // Pack builder: zero-run counting, slot writes and frame-close tracking.
    // Slots are cleared on transfer so that unused slots reach the output as 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            pack_cnt   <= '0;
            run        <= '0;
            flush_pend <= 1'b0;
            for (int k = 0; k < I; k++) begin
                pack_value[k] <= '0;
                pack_index[k] <= '0;
            end
        end else if (transfer) begin
            pack_cnt   <= '0;
            flush_pend <= 1'b0;
            for (int k = 0; k < I; k++) begin
                pack_value[k] <= '0;
                pack_index[k] <= '0;
            end
        end else if (accept) begin
            if (write_slot) begin
                // A run-break entry carries in_data (zero) and run (MAX_RUN).
                pack_value[pack_cnt[SLOT_W-1:0]] <= in_data;
                pack_index[pack_cnt[SLOT_W-1:0]] <= run;
                pack_cnt <= pack_cnt + 1'b1;
            end
            // Trailing zeros of a frame are dropped, so the run restarts on last.
            if (write_slot || in_last) begin
                run <= '0;
            end else begin
                run <= run + 1'b1;
            end
            if (in_last) begin
                flush_pend <= 1'b1;
            end
        end
    end

    // Output register: loads on transfer and holds until the consumer accepts.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_value <= '0;
            out_index <= '0;
            out_cnt   <= '0;
            out_last  <= 1'b0;
        end else if (transfer) begin
            out_valid <= 1'b1;
            out_value <= pack_value_flat;
            out_index <= pack_index_flat;
            out_cnt   <= pack_cnt;
            out_last  <= flush_pend;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_index_encoder_output.sv
// Bench for index_encoder_output: directed frames plus random sparse frames,
// scored against an entry-position model and a reference decoder.
module tb_index_encoder_output;

    localparam int I       = 4;
    localparam int DATA_W  = 16;
    localparam int IDX_W   = 4;
    localparam int CNT_W   = 3;
    localparam int MAX_RUN = 15;
    localparam int VEC_W   = I*DATA_W + I*IDX_W + CNT_W + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_ready = 1'b0;
    logic              in_ready;
    logic              out_valid;
    logic              out_last;
    logic [I*DATA_W-1:0] out_value;
    logic [I*IDX_W-1:0]  out_index;
    logic [CNT_W-1:0]    out_cnt;

    index_encoder_output #(.I(I), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_index (out_index),
        .out_cnt   (out_cnt),
        .out_last  (out_last)
    );

    // Clock
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    logic [VEC_W-1:0]  exp_q[$];
    logic [VEC_W-1:0]  model_q[$];
    logic [DATA_W-1:0] frame_q[$];
    logic [DATA_W-1:0] ref_dense_q[$];
    int                ref_len_q[$];
    logic [DATA_W-1:0] dec_val_q[$];
    int                dec_idx_q[$];
    int  ready_pct = 100;
    int  cyc = 0;
    int  hold_until = 0;
    logic held = 1'b0;
    logic [VEC_W-1:0] held_vec = '0;

    // Downstream ready, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc < hold_until) out_ready = 1'b0;
            else out_ready = ($urandom_range(1, 100) <= ready_pct);
        end
    end

    task automatic check(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: entry n sits at a dense position; its index is the gap to the
    // previous entry. A gap of MAX_RUN on a zero forces a run-break entry.
    // The closing vector holds whatever was encoded after the last full one.
    task automatic model_frame();
        int prev;
        int slot;
        int gap;
        logic [I*DATA_W-1:0] v;
        logic [I*IDX_W-1:0]  x;
        logic [VEC_W-1:0]    tmp;
        prev = -1; slot = 0; v = '0; x = '0;
        model_q.delete();
        for (int p = 0; p < frame_q.size(); p++) begin
            gap = p - prev - 1;
            if (frame_q[p] != 0 || gap == MAX_RUN) begin
                v[slot*DATA_W +: DATA_W] = frame_q[p];
                x[slot*IDX_W +: IDX_W]   = gap[IDX_W-1:0];
                slot++;
                prev = p;
                if (slot == I) begin
                    model_q.push_back({v, x, CNT_W'(I), 1'b0});
                    v = '0; x = '0; slot = 0;
                end
            end
        end
        if (slot > 0 || prev != frame_q.size() - 1 || model_q.size() == 0) begin
            model_q.push_back({v, x, CNT_W'(slot), 1'b1});
        end else begin
            tmp = model_q.pop_back();
            tmp[0] = 1'b1;
            model_q.push_back(tmp);
        end
    endtask

    task automatic pin(input string name, input int k, input logic [VEC_W-1:0] exp);
        if (k < model_q.size()) check(name, model_q[k], exp);
        else check(name, '0, exp);
    endtask

    task automatic send_elem(input logic [DATA_W-1:0] d, input logic last);
        int budget;
        budget = 0;
        in_valid = 1'b1; in_data = d; in_last = last;
        while (!in_ready && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL in_ready_timeout: got 0 expected 1 within 300 cycles");
        end
        @(negedge clk);
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    endtask

    // Queue the model's vectors and the reference frame, then drive frame_q.
    task automatic send_frame(input int gap_pct);
        model_frame();
        foreach (model_q[k]) exp_q.push_back(model_q[k]);
        foreach (frame_q[k]) ref_dense_q.push_back(frame_q[k]);
        ref_len_q.push_back(frame_q.size());
        for (int p = 0; p < frame_q.size(); p++) begin
            while ($urandom_range(1, 100) <= gap_pct) @(negedge clk);
            send_elem(frame_q[p], p == frame_q.size() - 1);
        end
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        check("drain", VEC_W'(exp_q.size()), '0);
    endtask

    // Reference decoder: rebuild the dense frame from received entries.
    task automatic check_frame();
        int L;
        int pos;
        logic ok;
        logic [DATA_W-1:0] dense [];
        if (ref_len_q.size() == 0) begin
            check("frame_unexpected", 1, 0);
        end else begin
            L = ref_len_q.pop_front();
            dense = new[L];
            foreach (dense[k]) dense[k] = '0;
            ok = 1'b1;
            pos = -1;
            foreach (dec_val_q[k]) begin
                pos += dec_idx_q[k] + 1;
                if (pos >= L) ok = 1'b0;
                else dense[pos] = dec_val_q[k];
            end
            for (int p = 0; p < L; p++) begin
                if (ref_dense_q.size() == 0) ok = 1'b0;
                else if (dense[p] !== ref_dense_q.pop_front()) ok = 1'b0;
            end
            check("frame_decode", VEC_W'(ok), 1);
        end
        dec_val_q.delete();
        dec_idx_q.delete();
    endtask

    // Compare step: every accepted vector against the model, plus hold checks.
    task automatic monitor_step();
        logic [VEC_W-1:0] act;
        act = {out_value, out_index, out_cnt, out_last};
        if (rst) begin
            held = 1'b0;
            dec_val_q.delete();
            dec_idx_q.delete();
        end else begin
            if (held) begin
                check("hold_valid", VEC_W'(out_valid), 1);
                check("hold_stable", act, held_vec);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("vector_unexpected", act, '0);
                else check("vector", act, exp_q.pop_front());
                for (int k = 0; k < int'(out_cnt) && k < I; k++) begin
                    dec_val_q.push_back(out_value[k*DATA_W +: DATA_W]);
                    dec_idx_q.push_back(int'(out_index[k*IDX_W +: IDX_W]));
                end
                if (out_last) check_frame();
            end
            held = out_valid && !out_ready;
            held_vec = act;
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        // Reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out_valid", VEC_W'(out_valid), 0);
        check("reset_in_ready", VEC_W'(in_ready), 1);
        check("reset_outputs", {out_value, out_index, out_cnt, out_last}, '0);
        rst = 1'b0;
        ready_pct = 100;
        @(negedge clk);

        // Mixed frame ending on a full vector
        frame_q = '{16'd0, 16'd5, 16'd0, 16'd0, 16'd7, 16'd3, 16'd0, 16'd9};
        model_frame();
        pin("model_t1", 0, {64'h0009_0003_0007_0005, 16'h1021, 3'd4, 1'b1});
        send_frame(0);

        // Long zero run forces a run-break entry
        frame_q.delete();
        repeat (20) frame_q.push_back(16'd0);
        frame_q.push_back(16'd4);
        model_frame();
        pin("model_t2", 0, {64'h0000_0000_0004_0000, 16'h004F, 3'd2, 1'b1});
        send_frame(0);

        // Output held low while a frame is packed
        wait_drain();
        frame_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
        model_frame();
        pin("model_t3a", 0, {64'h0004_0003_0002_0001, 16'h0000, 3'd4, 1'b0});
        pin("model_t3b", 1, {64'h0000_0000_0006_0005, 16'h0000, 3'd2, 1'b1});
        hold_until = cyc + 10;
        send_frame(0);
        check("in_ready_while_held", VEC_W'(in_ready), 0);

        // All-zero frame, then a frame checking the run restarted
        frame_q = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        model_frame();
        pin("model_t4", 0, {64'h0, 16'h0, 3'd0, 1'b1});
        send_frame(0);
        frame_q = '{16'd0, 16'd0, 16'd6};
        send_frame(0);
        wait_drain();

        // Reset in the middle of a frame
        send_elem(16'd3, 1'b0);
        send_elem(16'd4, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out_valid", VEC_W'(out_valid), 0);
        check("abort_in_ready", VEC_W'(in_ready), 1);
        frame_q = '{16'd0, 16'd8};
        model_frame();
        pin("model_t5", 0, {64'h0000_0000_0000_0008, 16'h0001, 3'd1, 1'b1});
        send_frame(0);

        // Random sparse frames with random backpressure and input gaps
        for (int f = 0; f < 40; f++) begin
            int len;
            int sparse;
            len = $urandom_range(1, 48);
            sparse = ($urandom_range(0, 3) == 0) ? 16 : 4;
            frame_q.delete();
            for (int p = 0; p < len; p++) begin
                if ($urandom_range(1, sparse) == 1) frame_q.push_back(16'($urandom_range(1, 65535)));
                else frame_q.push_back(16'd0);
            end
            case ($urandom_range(0, 2))
                0: ready_pct = 100;
                1: ready_pct = 70;
                default: ready_pct = 35;
            endcase
            send_frame($urandom_range(0, 1) * 20);
        end

        ready_pct = 100;
        wait_drain();
        repeat (4) @(negedge clk);
        check("frames_left", VEC_W'(ref_len_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
